usb_fe_tx_ctrl: RTL and testbench

//  Synthesizable USB 2.0 FS transmit sequencer for the device front end (usb_fe_if).

---
 rtl/usb_pkg.sv | 38 +++
 rtl/usb_tx_bit_enc.sv | 47 ++++
 rtl/usb_fe_tx_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_usb_fe_tx_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed transmit front end.
package usb_pkg;

    typedef enum logic [1:0] {
        LS_J,
        LS_K,
        LS_SE0
    } line_state_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J,
        ST_IPG
    } tx_state_e;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } tx_byte_t;

    localparam logic [7:0]  USB_SYNC_BYTE    = 8'h80;
    localparam int unsigned USB_STUFF_LEN    = 6;
    localparam int unsigned USB_EOP_SE0_BITS = 2;

    // {dp, dn} levels for a line state
    function automatic logic [1:0] ls_to_dpdn(input line_state_e ls);
        case (ls)
            LS_J:    return 2'b10;
            LS_K:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/usb_tx_bit_enc.sv
// NRZI line-level tracker and consecutive-ones counter for bit stuffing.
module usb_tx_bit_enc
    import usb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic bit_i,
    input  logic bit_strobe_i,
    input  logic init_i,
    output logic level_c_o,
    output logic stuff_req_o
);

    logic       level_q, level_d;
    logic [2:0] cnt_q, cnt_d;

    // level 1 = J, 0 = K; a stuffed bit is sent as a data 0
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (init_i) begin
            level_d = 1'b1;
            cnt_d   = '0;
        end else if (bit_strobe_i) begin
            if (bit_i) begin
                cnt_d = cnt_q + 3'd1;
            end else begin
                level_d = ~level_q;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_c_o   = level_d;
    assign stuff_req_o = (cnt_q == 3'(USB_STUFF_LEN));

endmodule

// File: rtl/usb_fe_tx_ctrl.sv
// USB FS transmit sequencer: SYNC, NRZI data with bit stuffing, EOP and inter-packet gap.
module usb_fe_tx_ctrl
    import usb_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 4,
    parameter int unsigned IPG_BITS    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_last_i,
    output logic       tx_ready_o,
    output logic       tx_busy_o,
    output logic       tx_underrun_o,
    output logic       tx_oe_o,
    output logic       dp_tx_o,
    output logic       dn_tx_o
);

    localparam int unsigned     PH_W     = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CLK_PER_BIT - 1);
    localparam logic [PH_W-1:0] PH_PRE   = PH_W'(CLK_PER_BIT - 2);
    localparam logic [3:0]      IPG_LAST = 4'(IPG_BITS - 1);

    tx_state_e       state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [2:0]      idx_q, idx_d;
    tx_byte_t        byte_q, byte_d;
    logic [3:0]      ipg_q, ipg_d;
    logic            start_q, start_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            und_q, und_d;
    logic            oe_q, oe_d;
    logic [1:0]      dpdn_q, dpdn_d;

    logic            enc_bit, enc_strobe, enc_init, level_c, stuff_req;
    logic            ls_load;
    line_state_e     ls_fixed;
    logic            bit_end;

    assign bit_end = (ph_q == PH_LAST);

    usb_tx_bit_enc u_enc (
        .clk          (clk),
        .rst_n        (rst_n),
        .bit_i        (enc_bit),
        .bit_strobe_i (enc_strobe),
        .init_i       (enc_init),
        .level_c_o    (level_c),
        .stuff_req_o  (stuff_req)
    );

    // Next bit is chosen on the last clock of the current one; the load slot is that same clock
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        idx_d      = idx_q;
        byte_d     = byte_q;
        ipg_d      = ipg_q;
        start_d    = start_q;
        ready_d    = 1'b0;
        busy_d     = busy_q;
        und_d      = 1'b0;
        oe_d       = oe_q;
        enc_bit    = 1'b0;
        enc_strobe = 1'b0;
        enc_init   = 1'b0;
        ls_load    = 1'b0;
        ls_fixed   = LS_J;
        if (state_q != ST_IDLE) begin
            ph_d = bit_end ? '0 : ph_q + PH_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                enc_init = ~start_q;
                ph_d     = '0;
                if (start_q) begin
                    start_d    = 1'b0;
                    state_d    = ST_SYNC;
                    idx_d      = '0;
                    byte_d     = '{last: 1'b0, data: USB_SYNC_BYTE};
                    enc_bit    = USB_SYNC_BYTE[0];
                    enc_strobe = 1'b1;
                    oe_d       = 1'b1;
                    busy_d     = 1'b1;
                end else if (tx_valid_i) begin
                    start_d = 1'b1;
                end
            end
            ST_SYNC, ST_DATA, ST_STUFF: begin
                if (ph_q == PH_PRE) begin
                    ready_d = (idx_q == 3'd7) && !byte_q.last && !stuff_req;
                end
                if (bit_end) begin
                    if (stuff_req) begin
                        state_d    = ST_STUFF;
                        enc_strobe = 1'b1;
                    end else if (idx_q != 3'd7) begin
                        state_d    = (state_q == ST_SYNC) ? ST_SYNC : ST_DATA;
                        idx_d      = idx_q + 3'd1;
                        enc_bit    = byte_q.data[idx_q + 3'd1];
                        enc_strobe = 1'b1;
                    end else if (ready_q && tx_valid_i) begin
                        state_d     = ST_DATA;
                        idx_d       = '0;
                        byte_d.data = tx_data_i;
                        byte_d.last = tx_last_i;
                        enc_bit     = tx_data_i[0];
                        enc_strobe  = 1'b1;
                    end else begin
                        und_d    = ready_q;
                        state_d  = ST_EOP_SE0;
                        idx_d    = '0;
                        ls_load  = 1'b1;
                        ls_fixed = LS_SE0;
                    end
                end
            end
            ST_EOP_SE0: begin
                if (bit_end) begin
                    if (idx_q == 3'(USB_EOP_SE0_BITS - 1)) begin
                        state_d  = ST_EOP_J;
                        ls_load  = 1'b1;
                        ls_fixed = LS_J;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_EOP_J: begin
                if (bit_end) begin
                    state_d = ST_IPG;
                    oe_d    = 1'b0;
                    ipg_d   = '0;
                end
            end
            ST_IPG: begin
                if (bit_end) begin
                    if (ipg_q == IPG_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        ipg_d = ipg_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level: encoder output for SYNC/data/stuff bits, fixed states for EOP
    always_comb begin
        dpdn_d = dpdn_q;
        if (enc_strobe) begin
            dpdn_d = ls_to_dpdn(level_c ? LS_J : LS_K);
        end else if (ls_load) begin
            dpdn_d = ls_to_dpdn(ls_fixed);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            ipg_q   <= '0;
            start_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            und_q   <= 1'b0;
            oe_q    <= 1'b0;
            dpdn_q  <= 2'b10;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            ipg_q   <= ipg_d;
            start_q <= start_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            und_q   <= und_d;
            oe_q    <= oe_d;
            dpdn_q  <= dpdn_d;
        end
    end

    assign tx_ready_o    = ready_q;
    assign tx_busy_o     = busy_q;
    assign tx_underrun_o = und_q;
    assign tx_oe_o       = oe_q;
    assign dp_tx_o       = dpdn_q[1];
    assign dn_tx_o       = dpdn_q[0];

endmodule

// File: tb/tb_usb_fe_tx_ctrl.sv
// Self-checking bench for usb_fe_tx_ctrl: reference NRZI/stuff encoder feeding a line-symbol scoreboard.
module tb_usb_fe_tx_ctrl;

    localparam int CPB = 4;
    localparam int IPG = 6;

    logic       clk;
    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready, tx_busy, tx_underrun, tx_oe, dp_tx, dn_tx;

    int checks = 0;
    int errors = 0;

    logic [1:0] sb[$];
    logic       m_lvl;
    int         m_cnt;

    typedef struct {
        logic [2:0][7:0] b;
        int              n;
        int              drop;
        int              exp_rdy;
        int              exp_und;
        int              exp_bits;
        int              exp_gap;
    } vec_t;

    vec_t vecs[6];

    usb_fe_tx_ctrl #(.CLK_PER_BIT(CPB), .IPG_BITS(IPG)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_valid_i    (tx_valid),
        .tx_data_i     (tx_data),
        .tx_last_i     (tx_last),
        .tx_ready_o    (tx_ready),
        .tx_busy_o     (tx_busy),
        .tx_underrun_o (tx_underrun),
        .tx_oe_o       (tx_oe),
        .dp_tx_o       (dp_tx),
        .dn_tx_o       (dn_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference line encoder: pushes one {dp,dn} symbol per bit time
    task automatic m_bit(input logic b);
        if (!b) begin
            m_lvl = ~m_lvl;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        sb.push_back(m_lvl ? 2'b10 : 2'b01);
        if (m_cnt == 6) begin
            m_lvl = ~m_lvl;
            m_cnt = 0;
            sb.push_back(m_lvl ? 2'b10 : 2'b01);
        end
    endtask

    task automatic m_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) m_bit(d[i]);
    endtask

    function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input int n, input int drop, input int rdy, input int und,
                                input int bits, input int gap);
        vec_t v;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
        v.n = n; v.drop = drop; v.exp_rdy = rdy; v.exp_und = und;
        v.exp_bits = bits; v.exp_gap = gap;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        int  sent, idx, oe_cyc, busy_cyc, rdy, und, first_t, gap;
        bit  pend, done;
        logic [1:0] exp_sym;
        sent = (v.drop != 0) ? v.drop : v.n;
        sb.delete();
        m_lvl = 1'b1;
        m_cnt = 0;
        m_byte(8'h80);
        for (int k = 0; k < sent; k++) m_byte(v.b[k]);
        sb.push_back(2'b00); sb.push_back(2'b00); sb.push_back(2'b10);

        tx_valid = 1'b1;
        tx_data  = v.b[0];
        tx_last  = (v.n == 1);
        idx = 0; oe_cyc = 0; busy_cyc = 0; rdy = 0; und = 0; first_t = 0; gap = 0;
        pend = 1'b0; done = 1'b0;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(posedge clk);
            #1;
            if (pend) begin
                pend = 1'b0;
                idx++;
                if ((v.drop != 0 && idx == v.drop) || idx >= v.n) begin
                    tx_valid = 1'b0;
                end else begin
                    tx_data = v.b[idx];
                    tx_last = (idx == v.n - 1);
                end
            end
            @(negedge clk);
            if (tx_ready) begin
                rdy++;
                if (rdy == 1) first_t = t;
                if (rdy == 2) gap = t - first_t;
                if (tx_valid) pend = 1'b1;
            end
            if (tx_underrun) begin
                und++;
                chk($sformatf("v%0d_und_se0", id), {dp_tx, dn_tx}, 2'b00);
            end
            if (tx_oe) begin
                if (oe_cyc == 0) chk($sformatf("v%0d_start_lat", id), t, 1);
                if (oe_cyc % CPB == CPB / 2) begin
                    exp_sym = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
                    chk($sformatf("v%0d_line_bit%0d", id, oe_cyc / CPB), {dp_tx, dn_tx}, exp_sym);
                end
                oe_cyc++;
            end
            if (tx_busy) busy_cyc++;
            else if (busy_cyc > 0) done = 1'b1;
        end
        tx_valid = 1'b0;
        chk($sformatf("v%0d_busy_end", id), done, 1);
        chk($sformatf("v%0d_sb_left", id), sb.size(), 0);
        chk($sformatf("v%0d_ready_cnt", id), rdy, v.exp_rdy);
        chk($sformatf("v%0d_underrun_cnt", id), und, v.exp_und);
        chk($sformatf("v%0d_oe_cycles", id), oe_cyc, v.exp_bits * CPB);
        chk($sformatf("v%0d_busy_cycles", id), busy_cyc, (v.exp_bits + IPG) * CPB);
        if (v.exp_gap != 0) chk($sformatf("v%0d_ready_gap", id), gap, v.exp_gap);
    endtask

    initial begin
        int cnt, low_oe, low_busy, und;
        bit seen;
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;

        vecs[0] = mk(8'h00, 8'h00, 8'h00, 1, 0, 1, 0, 19, 0);
        vecs[1] = mk(8'hFF, 8'h00, 8'h00, 1, 0, 1, 0, 20, 0);
        vecs[2] = mk(8'h2D, 8'h00, 8'h10, 3, 0, 3, 0, 35, 32);
        vecs[3] = mk(8'hA5, 8'h3C, 8'h00, 2, 1, 2, 1, 19, 32);
        vecs[4] = mk(8'hFF, 8'hFC, 8'h00, 2, 0, 2, 0, 29, 36);
        vecs[5] = mk(8'hFC, 8'h00, 8'h00, 2, 0, 2, 0, 28, 36);

        repeat (3) @(negedge clk);
        chk("rst_ready", tx_ready, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_underrun", tx_underrun, 0);
        chk("rst_oe", tx_oe, 0);
        chk("rst_dp", dp_tx, 1);
        chk("rst_dn", dn_tx, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset asserted during data bit 3 of the first byte
        tx_valid = 1'b1; tx_data = 8'h00; tx_last = 1'b0;
        cnt = 0;
        for (int t = 0; t < 200 && cnt < 11 * CPB + 1; t++) begin
            @(negedge clk);
            if (tx_oe) cnt++;
        end
        chk("mid_rst_reach", cnt, 11 * CPB + 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_oe", tx_oe, 0);
        chk("mid_rst_line", {dp_tx, dn_tx}, 2'b10);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_ready", tx_ready, 0);
        tx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[0], 10);

        // tx_valid held through the IPG must not start a packet before IDLE
        tx_valid = 1'b1; tx_data = 8'h00; tx_last = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            if (tx_oe) seen = 1'b1;
        end
        for (int t = 0; t < 300 && seen; t++) begin
            @(negedge clk);
            if (!tx_oe) seen = 1'b0;
        end
        chk("ipg_oe_fell", seen, 0);
        low_oe = 1; low_busy = 0;
        for (int t = 0; t < 300 && !tx_oe; t++) begin
            @(negedge clk);
            if (!tx_oe) low_oe++;
            if (!tx_busy) low_busy++;
        end
        chk("ipg_oe_low_cycles", low_oe, IPG * CPB + 2);
        chk("ipg_busy_low_cycles", low_busy, 2);
        // Second packet underruns at its SYNC load slot
        tx_valid = 1'b0;
        und = 0; seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            if (tx_underrun) und++;
            if (!tx_busy) seen = 1'b1;
        end
        chk("sync_underrun_cnt", und, 1);
        chk("sync_underrun_done", seen, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
